hilo_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair.
- It replaces the single-cycle, decode-only HI/LO write-enable handling.
- It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and signals busy while an operation is in flight.
- It provides HI/LO read data for MFHI/MFLO; the core stalls MFHI/MFLO on busy.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_divider.sv | 79 +++++++
 rtl/hilo_muldiv_unit.sv | 119 +++++++++++
 tb/tb_hilo_muldiv_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on operand magnitudes, DIV_STEPS quotient bits per step,
// with sign correction and divide-by-zero quotient override on the outputs.
module muldiv_divider #(
  parameter int WIDTH     = 32,
  parameter int DIV_STEPS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int N  = WIDTH / DIV_STEPS;
  localparam int CW = $clog2(N);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, div_zero;
  logic             a_neg, b_neg;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign last  = (cnt == CW'(N - 1));

  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    trial  = '0;
    for (int unsigned i = 0; i < DIV_STEPS; i++) begin
      trial  = {rem_nx, quo_nx[WIDTH-1]};
      quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial     = trial - {1'b0, dvs};
        quo_nx[0] = 1'b1;
      end
      rem_nx = trial[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      rem      <= '0;
      quo      <= a_neg ? -dividend : dividend;
      dvs      <= b_neg ? -divisor : divisor;
      cnt      <= '0;
      q_neg    <= a_neg ^ b_neg;
      r_neg    <= a_neg;
      div_zero <= (divisor == '0);
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // A zero divisor leaves the dividend magnitude in rem, so only the quotient needs overriding.
  assign quotient  = div_zero ? '1 : (q_neg ? -quo : quo);
  assign remainder = r_neg ? -rem : rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: FSM, multiply pipeline, abort handling
// and the combinational HI/LO read port.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_STEPS   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  muldiv_state_t      state;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_signed;
  logic [1:0]         mul_cnt;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic               accept, div_load, div_last;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign busy     = (state != IDLE);
  assign accept   = start & ~busy & ~abort;
  assign div_load = accept & ((op == OP_DIV) | (op == OP_DIVU));
  assign rd_data  = rd_sel ? hi : lo;

  // Sign-extend to 2*WIDTH so one truncated multiply serves both MULT and MULTU.
  assign ext_a   = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
  assign ext_b   = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
  assign product = ext_a * ext_b;

  muldiv_divider #(
    .WIDTH    (WIDTH),
    .DIV_STEPS(DIV_STEPS)
  ) u_divider (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (div_load),
    .step     ((state == DIV) & ~abort),
    .clear    (abort),
    .is_signed(op == OP_DIV),
    .dividend (op_a),
    .divisor  (op_b),
    .quotient (div_quo),
    .remainder(div_rem),
    .last     (div_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      mul_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mul_a      <= op_a;
                mul_b      <= op_b;
                mul_signed <= (op == OP_MULT);
                mul_cnt    <= '0;
                state      <= MUL;
              end
              OP_DIV, OP_DIVU: state <= DIV;
              OP_MTHI:         hi <= op_a;
              OP_MTLO:         lo <= op_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (abort) begin
            state   <= IDLE;
            mul_cnt <= '0;
          end else if (mul_cnt == 2'(MUL_LATENCY - 1)) begin
            {hi, lo} <= product;
            done     <= 1'b1;
            mul_cnt  <= '0;
            state    <= IDLE;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        DIV: begin
          if (abort)         state <= IDLE;
          else if (div_last) state <= FIX;
        end
        FIX: begin
          if (!abort) begin
            lo   <= div_quo;
            hi   <= div_rem;
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (default parameters, WIDTH=32).
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  muldiv_op_t       op = OP_MTHI;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             abort = 1'b0;
  logic             rd_sel = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv_unit #(
    .WIDTH      (WIDTH),
    .MUL_LATENCY(2),
    .DIV_STEPS  (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .op_a   (op_a),
    .op_b   (op_b),
    .abort  (abort),
    .rd_sel (rd_sel),
    .rd_data(rd_data),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic sel, output logic [WIDTH-1:0] val);
    rd_sel = sel;
    #1;
    val = rd_data;
  endtask

  // Present a one-cycle request; returns at the falling edge after the acceptance edge.
  task automatic issue(input muldiv_op_t o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input muldiv_op_t o,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_cycles, input logic [WIDTH-1:0] exp_hi,
                        input logic [WIDTH-1:0] exp_lo, input bit poke);
    int cycles = 0;
    int pulses = 0;
    logic [WIDTH-1:0] hi0, lo0, v;
    read_reg(1'b1, hi0);
    read_reg(1'b0, lo0);
    issue(o, a, b);
    while (busy && cycles < 200) begin
      cycles++;
      if (done) pulses++;
      if (poke && cycles == 5) begin
        start = 1'b1;
        op    = OP_MTLO;
        op_a  = 32'hDEAD_BEEF;
      end
      if (poke && cycles == 7) start = 1'b0;
      if (poke && cycles == 10) begin
        read_reg(1'b0, v);
        check_eq({tag, "_lo_held"}, v, lo0);
        read_reg(1'b1, v);
        check_eq({tag, "_hi_held"}, v, hi0);
      end
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, cycles, exp_cycles);
    if (done) pulses++;
    @(negedge clk);
    if (done) pulses++;
    check_eq({tag, "_done_pulses"}, pulses, 1);
    read_reg(1'b1, v);
    check_eq({tag, "_hi"}, v, exp_hi);
    read_reg(1'b0, v);
    check_eq({tag, "_lo"}, v, exp_lo);
  endtask

  initial begin
    logic [WIDTH-1:0] v, hi0, lo0;
    int pulses;

    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    read_reg(1'b1, v);
    check_eq("rst_hi", v, 0);
    read_reg(1'b0, v);
    check_eq("rst_lo", v, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("mult",    OP_MULT,  32'hFFFF_FFFD, 32'd5,         2, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_neg", OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op("div_nb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",    OP_DIVU,  32'd100,       32'd7,        33, 32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("divu_z",  OP_DIVU,  32'h0000_1234, 32'd0,        33, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_z",   OP_DIV,   32'hFFFF_FFFB, 32'd0,        33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // Abort a divide ten cycles into the operation.
    pulses = 0;
    read_reg(1'b1, hi0);
    read_reg(1'b0, lo0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (9) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check_eq("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy_after", busy, 0);
    repeat (40) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check_eq("abort_no_done", pulses, 0);
    read_reg(1'b1, v);
    check_eq("abort_hi", v, hi0);
    read_reg(1'b0, v);
    check_eq("abort_lo", v, lo0);

    // Abort in the same cycle as start drops the request.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = OP_MTLO; op_a = 32'h1111_2222;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", busy, 0);
    read_reg(1'b0, v);
    check_eq("abort_start_lo", v, lo0);

    // Undefined op code has no effect.
    issue(muldiv_op_t'(3'd6), 32'h3333_4444, 32'd1);
    check_eq("undef_busy", busy, 0);
    read_reg(1'b1, v);
    check_eq("undef_hi", v, hi0);

    issue(OP_MTLO, 32'hA5A5_A5A5, 32'd0);
    check_eq("mtlo_busy", busy, 0);
    check_eq("mtlo_done", done, 0);
    read_reg(1'b0, v);
    check_eq("mtlo_lo", v, 32'hA5A5_A5A5);
    issue(OP_MTHI, 32'h5A5A_0F0F, 32'd0);
    read_reg(1'b1, v);
    check_eq("mthi_hi", v, 32'h5A5A_0F0F);
    read_reg(1'b0, v);
    check_eq("mthi_lo_kept", v, 32'hA5A5_A5A5);

    // Asynchronous reset in the middle of a multiply.
    issue(OP_MULT, 32'd3, 32'd4);
    check_eq("mid_mult_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy, 0);
    read_reg(1'b1, v);
    check_eq("rst_mid_hi", v, 0);
    read_reg(1'b0, v);
    check_eq("rst_mid_lo", v, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("rst_mid_no_done", pulses, 0);
    read_reg(1'b0, v);
    check_eq("rst_mid_lo_after", v, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
